// File: rtl/mult_operand_gate.sv
// Operand-isolation and result-capture stage around a combinational multiplier.
// Optional saturating statistics counters are built when MULT_OPERAND_GATE_STATS_EN is defined.
module mult_operand_gate #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_y,
    output logic                 gate_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_y,
    output logic                 out_skip,
    output logic [CNT_W-1:0]     stat_total,
    output logic [CNT_W-1:0]     stat_skip
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] mul_a_d, mul_b_d;
    logic [PW-1:0]    out_y_d;
    logic             out_valid_d, out_skip_d, gate_en_d;
    logic             ops_loaded, ops_loaded_d;
    logic             accept_c, zero_c, repeat_c, skip_c;

    // Ready is combinational so a held result can be replaced in the same cycle it is taken.
    assign in_ready = rst_n & ((state == IDLE) | ((state == HOLD) & out_ready));
    assign accept_c = in_valid & in_ready;
    assign zero_c   = (in_a == '0) | (in_b == '0);
    assign repeat_c = ops_loaded & (in_a == mul_a) & (in_b == mul_b);
    assign skip_c   = zero_c | repeat_c;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            mul_a      <= '0;
            mul_b      <= '0;
            out_y      <= '0;
            out_valid  <= 1'b0;
            out_skip   <= 1'b0;
            gate_en    <= 1'b0;
            ops_loaded <= 1'b0;
        end else begin
            state      <= state_d;
            mul_a      <= mul_a_d;
            mul_b      <= mul_b_d;
            out_y      <= out_y_d;
            out_valid  <= out_valid_d;
            out_skip   <= out_skip_d;
            gate_en    <= gate_en_d;
            ops_loaded <= ops_loaded_d;
        end
    end

    // Next-state and next-output logic; acceptance overrides the per-state defaults.
    always_comb begin
        state_d      = state;
        mul_a_d      = mul_a;
        mul_b_d      = mul_b;
        out_y_d      = out_y;
        out_valid_d  = out_valid;
        out_skip_d   = out_skip;
        gate_en_d    = 1'b0;
        ops_loaded_d = ops_loaded;

        case (state)
            IDLE: ;
            CALC: begin
                out_y_d     = mul_y;
                out_skip_d  = 1'b0;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_c) begin
            if (zero_c) begin
                out_y_d     = '0;
                out_skip_d  = 1'b1;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end else if (repeat_c) begin
                out_y_d     = mul_y;
                out_skip_d  = 1'b1;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end else begin
                mul_a_d      = in_a;
                mul_b_d      = in_b;
                ops_loaded_d = 1'b1;
                gate_en_d    = 1'b1;
                out_valid_d  = 1'b0;
                state_d      = CALC;
            end
        end
    end

`ifdef MULT_OPERAND_GATE_STATS_EN
    logic [CNT_W-1:0] total_q, skip_q;

    // Saturating counters of accepted and skipped pairs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_q <= '0;
            skip_q  <= '0;
        end else if (accept_c) begin
            if (total_q != '1) total_q <= total_q + CNT_W'(1);
            if (skip_c && (skip_q != '1)) skip_q <= skip_q + CNT_W'(1);
        end
    end

    assign stat_total = total_q;
    assign stat_skip  = skip_q;
`else
    assign stat_total = '0;
    assign stat_skip  = '0;
`endif

endmodule
